// File: rtl/pcpi_pkg.sv
// Shared definitions for the PCPI initiator and its responders:
// status codes, driver state encoding and common constants.
package pcpi_pkg;

    localparam int PCPI_XLEN            = 32;
    localparam int PCPI_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        PCPI_DONE    = 2'b00,
        PCPI_ILLEGAL = 2'b01,
        PCPI_HANG    = 2'b10
    } pcpi_status_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } pcpi_state_e;

endpackage

// File: rtl/pcpi_driver.sv
// PCPI initiator: accepts one command, runs a single PCPI transaction,
// and reports result, status and cycle count on a response channel.
module pcpi_driver
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT  = PCPI_TIMEOUT_DEFAULT,
    parameter int MAX_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [PCPI_XLEN-1:0] cmd_insn,
    input  logic [PCPI_XLEN-1:0] cmd_rs1,
    input  logic [PCPI_XLEN-1:0] cmd_rs2,
    input  logic [PCPI_XLEN-1:0] cmd_rs3,
    output logic                 pcpi_valid,
    output logic [PCPI_XLEN-1:0] pcpi_insn,
    output logic [PCPI_XLEN-1:0] pcpi_rs1,
    output logic [PCPI_XLEN-1:0] pcpi_rs2,
    output logic [PCPI_XLEN-1:0] pcpi_rs3,
    input  logic                 pcpi_wr,
    input  logic [PCPI_XLEN-1:0] pcpi_rd,
    input  logic                 pcpi_wait,
    input  logic                 pcpi_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_wr,
    output logic [PCPI_XLEN-1:0] rsp_rd,
    output logic [1:0]           rsp_status,
    output logic [CNT_W-1:0]     rsp_cycles
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    pcpi_state_e          state_q;
    pcpi_status_e         end_status;
    logic                 cmd_ready_q;
    logic                 pcpi_valid_q;
    logic                 rsp_valid_q;
    logic                 rsp_wr_q;
    logic                 wait_seen_q;
    logic [PCPI_XLEN-1:0] insn_q;
    logic [PCPI_XLEN-1:0] rs1_q;
    logic [PCPI_XLEN-1:0] rs2_q;
    logic [PCPI_XLEN-1:0] rs3_q;
    logic [PCPI_XLEN-1:0] rsp_rd_q;
    pcpi_status_e         rsp_status_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [CNT_W-1:0]     rsp_cycles_q;
    logic [TO_W-1:0]      to_q;
    logic [TO_W-1:0]      to_d;
    logic                 claimed;
    logic                 hang_hit;
    logic                 timeout_hit;
    logic                 txn_end;

    // Once the responder has claimed the instruction, the no-wait timeout
    // is disarmed for the rest of the transaction even if wait drops.
    assign cnt_d       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign to_d        = to_q + TO_W'(1);
    assign claimed     = pcpi_wait || wait_seen_q;
    assign hang_hit    = (MAX_WAIT != 0) && (cnt_d >= CNT_W'(MAX_WAIT));
    assign timeout_hit = (to_d == TO_W'(TIMEOUT));
    assign txn_end     = pcpi_ready || (claimed && hang_hit) || (!claimed && timeout_hit);

    always_comb begin
        end_status = PCPI_ILLEGAL;
        if (pcpi_ready) begin
            end_status = PCPI_DONE;
        end else if (claimed) begin
            end_status = PCPI_HANG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b0;
            pcpi_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_wr_q     <= 1'b0;
            wait_seen_q  <= 1'b0;
            insn_q       <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs3_q        <= '0;
            rsp_rd_q     <= '0;
            rsp_status_q <= PCPI_DONE;
            cnt_q        <= '0;
            rsp_cycles_q <= '0;
            to_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        insn_q       <= cmd_insn;
                        rs1_q        <= cmd_rs1;
                        rs2_q        <= cmd_rs2;
                        rs3_q        <= cmd_rs3;
                        pcpi_valid_q <= 1'b1;
                        cmd_ready_q  <= 1'b0;
                        cnt_q        <= '0;
                        to_q         <= '0;
                        wait_seen_q  <= 1'b0;
                        state_q      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt_q       <= cnt_d;
                    to_q        <= claimed ? '0 : to_d;
                    wait_seen_q <= claimed;
                    if (txn_end) begin
                        pcpi_valid_q <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= end_status;
                        rsp_wr_q     <= pcpi_ready && pcpi_wr;
                        rsp_rd_q     <= pcpi_ready ? pcpi_rd : '0;
                        rsp_cycles_q <= cnt_d;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign pcpi_valid = pcpi_valid_q;
    assign pcpi_insn  = insn_q;
    assign pcpi_rs1   = rs1_q;
    assign pcpi_rs2   = rs2_q;
    assign pcpi_rs3   = rs3_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_wr     = rsp_wr_q;
    assign rsp_rd     = rsp_rd_q;
    assign rsp_status = rsp_status_q;
    assign rsp_cycles = rsp_cycles_q;

endmodule

// File: tb/tb_pcpi_driver.sv
// Bench for pcpi_driver: two instances (unlimited and capped wait) driven
// by a scripted responder and checked against a cycle-by-cycle rule model.
module tb_pcpi_driver;

    localparam int TIMEOUT = 16;
    localparam int MAXW_B  = 32;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        cmdValid;
    logic        rspReady;
    logic        pcpiWait;
    logic        pcpiReady;
    logic        pcpiWr;
    logic [31:0] cmdInsn, cmdRs1, cmdRs2, cmdRs3, pcpiRd;

    logic        aCmdValid, aPcpiWait, aPcpiReady, aRspReady;
    logic        bCmdValid, bPcpiWait, bPcpiReady, bRspReady;
    logic        aCmdReady, aPcpiValid, aRspValid, aRspWr;
    logic        bCmdReady, bPcpiValid, bRspValid, bRspWr;
    logic [31:0] aInsn, aRs1, aRs2, aRs3, aRspRd;
    logic [31:0] bInsn, bRs1, bRs2, bRs3, bRspRd;
    logic [1:0]  aRspStatus, bRspStatus;
    logic [15:0] aRspCycles, bRspCycles;

    logic          cmdReady, pcpiValid, rspValid;
    logic [127:0]  opsView, aOps, bOps;
    logic [50:0]   rspView, aRsp, bRsp;

    int checks;
    int errors;

    // Only the selected instance sees handshakes; the other stays idle.
    assign aCmdValid  = cmdValid  && !sel;
    assign bCmdValid  = cmdValid  &&  sel;
    assign aPcpiWait  = pcpiWait  && !sel;
    assign bPcpiWait  = pcpiWait  &&  sel;
    assign aPcpiReady = pcpiReady && !sel;
    assign bPcpiReady = pcpiReady &&  sel;
    assign aRspReady  = rspReady  && !sel;
    assign bRspReady  = rspReady  &&  sel;

    assign aOps      = {aInsn, aRs1, aRs2, aRs3};
    assign bOps      = {bInsn, bRs1, bRs2, bRs3};
    assign aRsp      = {aRspStatus, aRspWr, aRspRd, aRspCycles};
    assign bRsp      = {bRspStatus, bRspWr, bRspRd, bRspCycles};
    assign cmdReady  = sel ? bCmdReady  : aCmdReady;
    assign pcpiValid = sel ? bPcpiValid : aPcpiValid;
    assign rspValid  = sel ? bRspValid  : aRspValid;
    assign opsView   = sel ? bOps       : aOps;
    assign rspView   = sel ? bRsp       : aRsp;

    pcpi_driver #(.TIMEOUT(TIMEOUT), .MAX_WAIT(0), .CNT_W(16)) dutA (
        .clk(clk), .reset(reset),
        .cmd_valid(aCmdValid), .cmd_ready(aCmdReady),
        .cmd_insn(cmdInsn), .cmd_rs1(cmdRs1), .cmd_rs2(cmdRs2), .cmd_rs3(cmdRs3),
        .pcpi_valid(aPcpiValid), .pcpi_insn(aInsn),
        .pcpi_rs1(aRs1), .pcpi_rs2(aRs2), .pcpi_rs3(aRs3),
        .pcpi_wr(pcpiWr), .pcpi_rd(pcpiRd), .pcpi_wait(aPcpiWait), .pcpi_ready(aPcpiReady),
        .rsp_valid(aRspValid), .rsp_ready(aRspReady), .rsp_wr(aRspWr),
        .rsp_rd(aRspRd), .rsp_status(aRspStatus), .rsp_cycles(aRspCycles)
    );

    pcpi_driver #(.TIMEOUT(TIMEOUT), .MAX_WAIT(MAXW_B), .CNT_W(16)) dutB (
        .clk(clk), .reset(reset),
        .cmd_valid(bCmdValid), .cmd_ready(bCmdReady),
        .cmd_insn(cmdInsn), .cmd_rs1(cmdRs1), .cmd_rs2(cmdRs2), .cmd_rs3(cmdRs3),
        .pcpi_valid(bPcpiValid), .pcpi_insn(bInsn),
        .pcpi_rs1(bRs1), .pcpi_rs2(bRs2), .pcpi_rs3(bRs3),
        .pcpi_wr(pcpiWr), .pcpi_rd(pcpiRd), .pcpi_wait(bPcpiWait), .pcpi_ready(bPcpiReady),
        .rsp_valid(bRspValid), .rsp_ready(bRspReady), .rsp_wr(bRspWr),
        .rsp_rd(bRspRd), .rsp_status(bRspStatus), .rsp_cycles(bRspCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference rules: the transaction ends on the first busy cycle k where
    // ready is seen, or the claimed run reaches the cap, or TIMEOUT unclaimed cycles pass.
    function automatic void modelTxn(input int waitAt, input int readyAt, input int maxW,
                                     output int endCyc, output logic [1:0] status);
        bit claimed;
        claimed = 0;
        endCyc  = 1000;
        status  = 2'b11;
        for (int k = 1; k <= 1000; k++) begin
            if (waitAt > 0 && k >= waitAt) claimed = 1;
            if (k == readyAt) begin endCyc = k; status = 2'b00; return; end
            if (claimed && maxW != 0 && k >= maxW) begin endCyc = k; status = 2'b10; return; end
            if (!claimed && k >= TIMEOUT) begin endCyc = k; status = 2'b01; return; end
        end
    endfunction

    task automatic noise();
        pcpiReady = 1'($urandom);
        pcpiWait  = 1'($urandom);
        pcpiWr    = 1'($urandom);
        pcpiRd    = $urandom;
    endtask

    task automatic selectDut(input logic d);
        sel = d;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [31:0] insn, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [31:0] rs3,
                                 input int waitAt, input int waitLen, input int readyAt,
                                 input logic wr, input logic [31:0] rd,
                                 input int stall, input bit holdValid);
        int endCyc;
        int guard;
        logic [1:0] expStatus;
        logic [50:0] expRsp;
        modelTxn(waitAt, readyAt, sel ? MAXW_B : 0, endCyc, expStatus);
        expRsp = {expStatus, (expStatus == 2'b00) ? wr : 1'b0,
                  (expStatus == 2'b00) ? rd : 32'h0, 16'(endCyc)};
        cmdInsn = insn; cmdRs1 = rs1; cmdRs2 = rs2; cmdRs3 = rs3;
        cmdValid = 1'b1;
        guard = 0;
        while (!cmdReady && guard < 20) begin
            noise();
            @(negedge clk);
            guard++;
        end
        checkOutput("cmd_ready_accept", 128'(cmdReady), 128'(1));
        @(negedge clk);
        if (!holdValid) cmdValid = 1'b0;
        for (int k = 1; k <= endCyc; k++) begin
            checkOutput("pcpi_valid_busy", 128'(pcpiValid), 128'(1));
            checkOutput("pcpi_ops_stable", opsView, {insn, rs1, rs2, rs3});
            checkOutput("rsp_valid_busy", 128'(rspValid), 128'(0));
            pcpiWait  = (waitAt > 0) && (k >= waitAt) && (k < waitAt + waitLen);
            pcpiReady = (k == readyAt);
            pcpiWr    = (k == readyAt) ? wr : 1'($urandom);
            pcpiRd    = (k == readyAt) ? rd : $urandom;
            @(negedge clk);
        end
        for (int s = 0; s <= stall; s++) begin
            checkOutput("pcpi_valid_resp", 128'(pcpiValid), 128'(0));
            checkOutput("rsp_valid", 128'(rspValid), 128'(1));
            checkOutput("cmd_ready_resp", 128'(cmdReady), 128'(0));
            checkOutput("rsp_fields", 128'(rspView), 128'(expRsp));
            noise();
            rspReady = (s == stall);
            @(negedge clk);
        end
        rspReady = 1'b0;
        checkOutput("rsp_valid_drop", 128'(rspValid), 128'(0));
        checkOutput("pcpi_valid_gap", 128'(pcpiValid), 128'(0));
        checkOutput("cmd_ready_idle", 128'(cmdReady), 128'(1));
    endtask

    initial begin
        checks = 0; errors = 0;
        sel = 1'b0; reset = 1'b1;
        cmdValid = 1'b0; rspReady = 1'b0;
        pcpiWait = 1'b0; pcpiReady = 1'b0; pcpiWr = 1'b0; pcpiRd = '0;
        cmdInsn = '0; cmdRs1 = '0; cmdRs2 = '0; cmdRs3 = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_cmd_ready_a", 128'(aCmdReady), 128'(0));
        checkOutput("rst_cmd_ready_b", 128'(bCmdReady), 128'(0));
        checkOutput("rst_pcpi_valid_a", 128'(aPcpiValid), 128'(0));
        checkOutput("rst_rsp_valid_a", 128'(aRspValid), 128'(0));
        checkOutput("rst_ops_a", aOps, 128'(0));
        checkOutput("rst_rsp_a", 128'(aRsp), 128'(0));
        checkOutput("rst_rsp_b", 128'(bRsp), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_cmd_ready", 128'(aCmdReady), 128'(1));

        applyStimulus(32'h60001013, 32'h00F0F000, $urandom, $urandom, 0, 0, 3, 1'b1, 32'h14, 0, 0);
        applyStimulus($urandom, $urandom, $urandom, $urandom, 0, 0, 0, 1'b0, 32'h0, 1, 0);
        applyStimulus($urandom, $urandom, $urandom, $urandom, 2, 100, 40, 1'b1, $urandom, 0, 0);
        applyStimulus($urandom, $urandom, $urandom, $urandom, 3, 2, 30, 1'b1, $urandom, 0, 0);
        applyStimulus($urandom, $urandom, $urandom, $urandom, 1, 1, 1, 1'b0, $urandom, 5, 0);
        selectDut(1'b1);
        applyStimulus($urandom, $urandom, $urandom, $urandom, 2, 100, 40, 1'b1, $urandom, 0, 0);
        selectDut(1'b0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus($urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3), 10,
                          $urandom_range(1, 8), 1'($urandom), $urandom, $urandom_range(0, 3), 1);
        end
        cmdValid = 1'b0;

        for (int i = 0; i < 16; i++) begin
            int waitAt, readyAt;
            selectDut(1'($urandom));
            waitAt  = $urandom_range(0, 20);
            readyAt = $urandom_range(0, 60);
            if (!sel && waitAt != 0 && readyAt == 0) readyAt = 50;
            applyStimulus($urandom, $urandom, $urandom, $urandom, waitAt, $urandom_range(1, 50),
                          readyAt, 1'($urandom), $urandom, $urandom_range(0, 4), 0);
        end

        selectDut(1'b0);
        pcpiWait = 1'b0; pcpiReady = 1'b0;
        cmdInsn = $urandom; cmdValid = 1'b1;
        checkOutput("rstmid_cmd_ready", 128'(cmdReady), 128'(1));
        @(negedge clk);
        cmdValid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstmid_busy", 128'(pcpiValid), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_pcpi_valid", 128'(pcpiValid), 128'(0));
        checkOutput("rstmid_rsp_valid", 128'(rspValid), 128'(0));
        checkOutput("rstmid_cmd_ready_low", 128'(cmdReady), 128'(0));
        reset = 1'b0;
        pcpiReady = 1'b1; pcpiWr = 1'b1; pcpiRd = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("rstmid_cmd_ready_back", 128'(cmdReady), 128'(1));
        checkOutput("rstmid_no_rsp", 128'(rspValid), 128'(0));
        pcpiReady = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_no_rsp_later", 128'(rspValid), 128'(0));
        checkOutput("rstmid_pcpi_idle", 128'(pcpiValid), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of run expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pcpi_driver.md
Name: pcpi_driver

Overview:
- PCPI initiator: takes co-processor instruction commands on a valid/ready command channel and drives one PCPI transaction at a time.
- Returns the result, a status code and the transaction cycle count on a valid/ready response channel.
- Lets rvb_pcpi and future PCPI responders be exercised standalone, without a CPU core.
- Matches the core's PCPI initiator semantics, including the no-wait illegal-instruction timeout.

Parameters:
- TIMEOUT, 16: cycles pcpi_valid may stay high with neither pcpi_wait nor pcpi_ready before the instruction is declared illegal.
- MAX_WAIT, 0: cap on total transaction cycles once pcpi_wait has been seen; 0 means unlimited.
- CNT_W, 16: width of the cycle counter and of rsp_cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver idle and able to accept a command.
- cmd_insn  in  32  instruction word.
- cmd_rs1  in  32  operand 1.
- cmd_rs2  in  32  operand 2.
- cmd_rs3  in  32  operand 3.
- pcpi_valid  out  1  transaction active.
- pcpi_insn  out  32  registered instruction.
- pcpi_rs1  out  32  registered operand 1.
- pcpi_rs2  out  32  registered operand 2.
- pcpi_rs3  out  32  registered operand 3.
- pcpi_wr  in  1  responder requests a register write.
- pcpi_rd  in  32  responder result.
- pcpi_wait  in  1  responder has claimed the instruction.
- pcpi_ready  in  1  responder done.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_wr  out  1  captured pcpi_wr.
- rsp_rd  out  32  captured pcpi_rd; 0 unless status is DONE.
- rsp_status  out  2  00 DONE, 01 ILLEGAL, 10 HANG.
- rsp_cycles  out  CNT_W  cycles pcpi_valid was high, saturating.

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset (synchronous, active-high): state=IDLE. pcpi_valid, rsp_valid, all pcpi_* and rsp_* data outputs = 0. cmd_ready=0 while reset is high.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready at edge N: latch insn/rs1-3 into pcpi_*; pcpi_valid=1 from cycle N+1; go to BUSY; clear cycle and timeout counters.
- BUSY:
  - Operands stay stable; cycle counter +1 each cycle, saturating at 2^CNT_W-1.
  - pcpi_ready sampled high: capture pcpi_wr/pcpi_rd; status=DONE; pcpi_valid=0 and rsp_valid=1 next cycle; go to RESP.
  - Otherwise, pcpi_wait seen (this cycle or earlier): timeout counter held at 0. If MAX_WAIT!=0 and the cycle count reaches MAX_WAIT, status=HANG with rd=0, wr=0.
  - Otherwise, timeout counter +1. When it reaches TIMEOUT (pcpi_valid high TIMEOUT cycles with no wait/ready), status=ILLEGAL with rd=0, wr=0.
  - pcpi_wait is sticky per transaction: deasserting it later does not re-arm the timeout.
- Priority in the same cycle: pcpi_ready > HANG > ILLEGAL.
- RESP:
  - rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid=0 next cycle; go to IDLE.
  - pcpi_valid is therefore low for at least 2 cycles between transactions.
- pcpi_ready/pcpi_wait/pcpi_wr while in IDLE or RESP: ignored.
- Latency: minimum pcpi_ready at N+1 gives rsp_valid at N+2 with rsp_cycles=1.
- Reset mid-transaction: pcpi_valid and rsp_valid low on the next cycle; the in-flight result is discarded; no response is issued.

Decomposition:
- Package pcpi_pkg:
  - status encodings PCPI_DONE/PCPI_ILLEGAL/PCPI_HANG;
  - state enum;
  - PCPI_XLEN=32;
  - default TIMEOUT constant, shared with the responder.
- No sub-module needed; the two counters stay inline in the single FSM module.

Test Plan:
- Fixed-latency responder: insn 0x60001013, rs1=0x00F0F000, ready+wr after 3 cycles with rd=0x14 -> rsp_status=00, rsp_wr=1, rsp_rd=0x14, rsp_cycles=3, pcpi_valid low the cycle after ready.
- Silent responder (wait/ready never asserted), TIMEOUT=16 -> rsp_status=01, rsp_rd=0, rsp_cycles=16, pcpi_valid high for exactly 16 cycles.
- Responder asserts wait at cycle 2 and ready at cycle 40, MAX_WAIT=0 -> status=00, rsp_cycles=40, no timeout. Same run with MAX_WAIT=32 -> status=10, rsp_cycles=32.
- Ready and wait asserted together in the first cycle with wr=0 -> status=00, rsp_wr=0, rsp_cycles=1. Hold rsp_ready low for 5 cycles -> rsp_* stable and cmd_ready=0 throughout.
- Back-to-back: 4 commands with cmd_valid held high and random rsp_ready stalls -> responses in order, pcpi_valid low ≥2 cycles between transactions, operands stable during BUSY.
- Reset asserted in BUSY at cycle 3 -> next cycle pcpi_valid=0, rsp_valid=0; a later pcpi_ready is ignored; cmd_ready=1 the cycle after reset drops.
